grid_mem_arbiter: RTL and testbench

GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

---
 rtl/grid_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_grid_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// Two-requester arbiter (display scanner, game FSM) for a synchronous grid RAM.
// Optional game-starvation guard: define GRID_ARB_FAIRNESS_EN.
module grid_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_grant,
  output logic [DATA_W-1:0] game_rdata,
  output logic              game_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state | meaning
  // ARB   | sample requests, register winner's access
  // ISSUE | access on RAM pins, requests ignored
  typedef enum logic {ARB, ISSUE} state_t;

  state_t state;
  logic   issue_rd, issue_game;
  logic   rd_pend, rd_game;
  logic   force_game, game_wins, disp_wins;

`ifdef GRID_ARB_FAIRNESS_EN
  logic [3:0] wait_cnt;

  assign force_game = (wait_cnt == 4'(MAX_WAIT));

  // Counts consecutive contested display wins; any game win or idle game clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (state == ARB) begin
      if (!game_req || game_wins)
        wait_cnt <= 4'd0;
      else if (disp_req)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign force_game = 1'b0;
`endif

  assign game_wins = game_req && (!disp_req || force_game);
  assign disp_wins = disp_req && !game_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      disp_grant  <= 1'b0;
      game_grant  <= 1'b0;
      disp_rvalid <= 1'b0;
      game_rvalid <= 1'b0;
      disp_rdata  <= '0;
      game_rdata  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      issue_rd    <= 1'b0;
      issue_game  <= 1'b0;
      rd_pend     <= 1'b0;
      rd_game     <= 1'b0;
    end else begin
      disp_grant  <= 1'b0;
      game_grant  <= 1'b0;
      mem_we      <= 1'b0;
      disp_rvalid <= 1'b0;
      game_rvalid <= 1'b0;
      rd_pend     <= 1'b0;
      case (state)
        ARB: begin
          if (game_wins) begin
            mem_addr   <= game_addr;
            mem_wdata  <= game_wdata;
            mem_we     <= game_we;
            game_grant <= 1'b1;
            issue_rd   <= !game_we;
            issue_game <= 1'b1;
            state      <= ISSUE;
          end else if (disp_wins) begin
            mem_addr   <= disp_addr;
            disp_grant <= 1'b1;
            issue_rd   <= 1'b1;
            issue_game <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // RAM samples mem_addr this cycle; data returns next cycle.
          rd_pend  <= issue_rd;
          rd_game  <= issue_game;
          issue_rd <= 1'b0;
          state    <= ARB;
        end
        default: state <= ARB;
      endcase
      if (rd_pend) begin
        if (rd_game) begin
          game_rdata  <= mem_rdata;
          game_rvalid <= 1'b1;
        end else begin
          disp_rdata  <= mem_rdata;
          disp_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a behavioural synchronous RAM.
// Contested-grant expectations follow GRID_ARB_FAIRNESS_EN when defined.
module tb_grid_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       disp_req, disp_grant, disp_rvalid;
  logic [7:0] disp_addr, disp_rdata;
  logic       game_req, game_we, game_grant, game_rvalid;
  logic [7:0] game_addr, game_wdata, game_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [7:0] ram [256];

  int n_vec = 0;
  int n_err = 0;

  grid_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_grant(game_grant), .game_rdata(game_rdata),
    .game_rvalid(game_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    game_req = 1'b1; game_we = 1'b1; game_addr = a; game_wdata = d;
    tick();
    game_req = 1'b0; game_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if ({disp_grant, game_grant, mem_we} !== 3'b000) begin n_err++;
      $display("FAIL reset_grants_we got %b want 000", {disp_grant, game_grant, mem_we}); end
    n_vec++; if ({disp_rvalid, game_rvalid} !== 2'b00) begin n_err++;
      $display("FAIL reset_rvalid got %b want 00", {disp_rvalid, game_rvalid}); end
    n_vec++; if ({mem_addr, mem_wdata, disp_rdata, game_rdata} !== 32'h0) begin n_err++;
      $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, disp_rdata, game_rdata}); end
  endtask

  task automatic test_game_write();
    logic seen_rv;
    game_req = 1'b1; game_we = 1'b1; game_addr = 8'h12; game_wdata = 8'hA5;
    tick();
    game_req = 1'b0; game_we = 1'b0;
    n_vec++; if ({game_grant, disp_grant, mem_we} !== 3'b101) begin n_err++;
      $display("FAIL wr_grant_we got %b want 101", {game_grant, disp_grant, mem_we}); end
    n_vec++; if ({mem_addr, mem_wdata} !== 16'h12A5) begin n_err++;
      $display("FAIL wr_addr_data got %h want 12a5", {mem_addr, mem_wdata}); end
    seen_rv = game_rvalid;
    tick();
    n_vec++; if ({game_grant, mem_we} !== 2'b00) begin n_err++;
      $display("FAIL wr_we_pulse got %b want 00", {game_grant, mem_we}); end
    for (int i = 0; i < 3; i++) begin
      seen_rv |= game_rvalid;
      tick();
    end
    n_vec++; if (seen_rv !== 1'b0) begin n_err++;
      $display("FAIL wr_no_rvalid got %b want 0", seen_rv); end
  endtask

  task automatic test_game_read();
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'h12; game_wdata = 8'h00;
    tick();
    game_req = 1'b0;
    n_vec++; if ({game_grant, mem_we, mem_addr} !== {2'b10, 8'h12}) begin n_err++;
      $display("FAIL rd_grant got %b/%b/%h want 1/0/12", game_grant, mem_we, mem_addr); end
    tick();
    n_vec++; if (game_rvalid !== 1'b0) begin n_err++;
      $display("FAIL rd_early_rvalid got %b want 0", game_rvalid); end
    tick();
    n_vec++; if ({game_rvalid, disp_rvalid, game_rdata} !== {2'b10, 8'hA5}) begin n_err++;
      $display("FAIL rd_data got %b/%b/%h want 1/0/a5", game_rvalid, disp_rvalid, game_rdata); end
    tick();
    n_vec++; if (game_rvalid !== 1'b0) begin n_err++;
      $display("FAIL rd_rvalid_pulse got %b want 0", game_rvalid); end
  endtask

  task automatic test_disp_read_top_addr();
    do_write(8'hFF, 8'h3C);
    tick();
    disp_req = 1'b1; disp_addr = 8'hFF;
    tick();
    disp_req = 1'b0;
    n_vec++; if ({disp_grant, game_grant, mem_addr} !== {2'b10, 8'hFF}) begin n_err++;
      $display("FAIL disp_grant got %b/%b/%h want 1/0/ff", disp_grant, game_grant, mem_addr); end
    tick();
    n_vec++; if ({disp_grant, disp_rvalid} !== 2'b00) begin n_err++;
      $display("FAIL disp_n2 got %b want 00", {disp_grant, disp_rvalid}); end
    tick();
    n_vec++; if ({disp_rvalid, game_rvalid, disp_rdata} !== {2'b10, 8'h3C}) begin n_err++;
      $display("FAIL disp_data got %b/%b/%h want 1/0/3c", disp_rvalid, game_rvalid, disp_rdata); end
    n_vec++; if (game_rdata !== 8'hA5) begin n_err++;
      $display("FAIL disp_game_rdata_kept got %h want a5", game_rdata); end
    tick(); tick();
  endtask

  task automatic test_contested();
    logic [15:0] got_d, got_g, exp_d, exp_g;
    exp_d = '0; exp_g = '0;
    for (int i = 0; i < 16; i += 2) begin
`ifdef GRID_ARB_FAIRNESS_EN
      if ((i / 2) % 4 == 3) exp_g[i] = 1'b1; else exp_d[i] = 1'b1;
`else
      exp_d[i] = 1'b1;
`endif
    end
    disp_req = 1'b1; disp_addr = 8'h40;
    game_req = 1'b1; game_we = 1'b0; game_addr = 8'h20;
    for (int i = 0; i < 16; i++) begin
      tick();
      got_d[i] = disp_grant;
      got_g[i] = game_grant;
    end
    n_vec++; if (got_d !== exp_d) begin n_err++;
      $display("FAIL contest_disp_grants got %b want %b", got_d, exp_d); end
    n_vec++; if (got_g !== exp_g) begin n_err++;
      $display("FAIL contest_game_grants got %b want %b", got_g, exp_g); end
    disp_req = 1'b0;
    tick();
    game_req = 1'b0;
    n_vec++; if ({game_grant, disp_grant} !== 2'b10) begin n_err++;
      $display("FAIL contest_release got %b want 10", {game_grant, disp_grant}); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_mid_read();
    logic seen_rv;
    do_write(8'h05, 8'h77);
    tick();
    disp_req = 1'b1; disp_addr = 8'hFF;
    tick();
    disp_req = 1'b0;
    n_vec++; if (disp_grant !== 1'b1) begin n_err++;
      $display("FAIL rst_mid_grant got %b want 1", disp_grant); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    disp_req = 1'b1; disp_addr = 8'h05;
    n_vec++; if ({disp_rvalid, game_rvalid, disp_grant, game_grant, mem_we} !== 5'b0) begin n_err++;
      $display("FAIL rst_mid_ctrl got %b want 00000",
               {disp_rvalid, game_rvalid, disp_grant, game_grant, mem_we}); end
    n_vec++; if ({mem_addr, mem_wdata, disp_rdata, game_rdata} !== 32'h0) begin n_err++;
      $display("FAIL rst_mid_data got %h want 0", {mem_addr, mem_wdata, disp_rdata, game_rdata}); end
    tick();
    disp_req = 1'b0;
    n_vec++; if ({disp_grant, mem_addr} !== {1'b1, 8'h05}) begin n_err++;
      $display("FAIL rst_first_grant got %b/%h want 1/05", disp_grant, mem_addr); end
    seen_rv = disp_rvalid;
    tick();
    seen_rv |= disp_rvalid;
    n_vec++; if (seen_rv !== 1'b0) begin n_err++;
      $display("FAIL rst_stale_rvalid got %b want 0", seen_rv); end
    tick();
    n_vec++; if ({disp_rvalid, disp_rdata} !== {1'b1, 8'h77}) begin n_err++;
      $display("FAIL rst_post_read got %b/%h want 1/77", disp_rvalid, disp_rdata); end
  endtask

  initial begin
    reset = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    #2;
    test_reset();
    test_game_write();
    test_game_read();
    test_disp_read_top_addr();
    test_contested();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
